// File: rtl/alu_host_pkg.sv
// alu_host_pkg: shared definitions for the UART ALU host initiator.
//   - 3-bit state encoding for the host FSM (IDLE .. DONE)
//   - FRAME_LEN: number of bytes sent per request (A, B, OP)
package alu_host_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEND_A  = 3'd1;
    localparam logic [2:0] ST_SEND_B  = 3'd2;
    localparam logic [2:0] ST_SEND_OP = 3'd3;
    localparam logic [2:0] ST_WAIT_RX = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SEND_A  = ST_SEND_A,
        SEND_B  = ST_SEND_B,
        SEND_OP = ST_SEND_OP,
        WAIT_RX = ST_WAIT_RX,
        DONE    = ST_DONE
    } state_t;

    localparam int FRAME_LEN = 3;

endpackage

// File: rtl/alu_host_tmo_cnt.sv
// alu_host_tmo_cnt: down-counter bounding the wait for a result byte.
// Parameters:
//   MAX      number of enabled cycles before expiry (>= 1)
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high
//   clear    in   reload the counter with MAX
//   enable   in   count one waiting cycle
//   expired  out  high in the enabled cycle that is the MAX-th since clear
module alu_host_tmo_cnt #(
    parameter int MAX = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= W'(MAX);
        end else if (enable && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Combinational so the owner can leave the wait state on the very
    // edge that completes the MAX-th waiting cycle.
    assign expired = enable && (cnt_q == W'(1));

endmodule

// File: rtl/alu_uart_host.sv
// alu_uart_host: host-side initiator for the UART ALU link.
// Sends A, B, OP into the UART TX FIFO, then waits for one result byte
// from the RX FIFO and reports it with a one-cycle done pulse.
//
// Optional feature: define ALU_HOST_TIMEOUT_EN to bound the result wait
// to TIMEOUT_CYCLES cycles (done with timeout=1, result=0x00 on expiry).
//
// Handshake: wr_uart is a write strobe, asserted only when tx_full=0, and
// each asserted cycle transfers exactly one byte on the rising edge.
// rd_uart pops the RX FIFO head, asserted only when rx_empty=0; r_data is
// consumed on the same edge.
//
// Ports:
//   clk, reset           clock / asynchronous active-high reset
//   start, a, b, op      request strobe and operands (sampled in IDLE)
//   busy, done, result   status, completion pulse, result byte
//   timeout              high with done when the wait expired
//   wr_uart, w_data      TX FIFO write side, tx_full back-pressure
//   rd_uart, r_data      RX FIFO read side, rx_empty flag
//   state_dbg            current FSM state (debug)
module alu_uart_host
    import alu_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] op,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       timeout,
    output logic       wr_uart,
    output logic [7:0] w_data,
    input  logic       tx_full,
    output logic       rd_uart,
    input  logic [7:0] r_data,
    input  logic       rx_empty,
    output logic [2:0] state_dbg
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("alu_uart_host: TIMEOUT_CYCLES must be >= 1");
    end

    state_t     state_q, state_d;
    logic [7:0] a_q, b_q, op_q;
    logic [7:0] result_q;
    logic       accept;
    logic       rx_fire;
    logic       expired;

    assign accept  = (state_q == IDLE) && start;
    assign rx_fire = (state_q == WAIT_RX) && rd_uart;

`ifdef ALU_HOST_TIMEOUT_EN
    logic wait_clear;
    logic wait_en;
    logic timeout_q;

    // Reload on the edge that writes OP, i.e. on entry into WAIT_RX.
    assign wait_clear = (state_q == SEND_OP) && wr_uart;
    assign wait_en    = (state_q == WAIT_RX) && rx_empty;

    alu_host_tmo_cnt #(
        .MAX(TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_en),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (accept || rx_fire) begin
            timeout_q <= 1'b0;
        end else if (state_q == WAIT_RX && expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q && (state_q == DONE);
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = SEND_A;
            SEND_A:  if (wr_uart) state_d = SEND_B;
            SEND_B:  if (wr_uart) state_d = SEND_OP;
            SEND_OP: if (wr_uart) state_d = WAIT_RX;
            WAIT_RX: if (rx_fire || expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 8'h00;
            result_q <= 8'h00;
        end else begin
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
            // A byte present on the expiry cycle wins over the timeout.
            if (rx_fire) begin
                result_q <= r_data;
            end else if (state_q == WAIT_RX && expired) begin
                result_q <= 8'h00;
            end
        end
    end

    // Outputs
    always_comb begin
        wr_uart = 1'b0;
        w_data  = 8'h00;
        case (state_q)
            SEND_A:  begin w_data = a_q;  wr_uart = ~tx_full; end
            SEND_B:  begin w_data = b_q;  wr_uart = ~tx_full; end
            SEND_OP: begin w_data = op_q; wr_uart = ~tx_full; end
            default: begin w_data = 8'h00; wr_uart = 1'b0; end
        endcase
    end

    // IDLE pops and discards stale RX bytes; gated by reset so nothing is
    // popped while the block is held in reset.
    assign rd_uart   = ((state_q == IDLE) || (state_q == WAIT_RX)) && ~rx_empty && ~reset;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_uart_host.sv
module tb_alu_uart_host;
  import alu_host_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00, op = 8'h00;
  logic       busy, done, timeout, wr_uart, rd_uart;
  logic [7:0] result, w_data;
  logic       tx_full = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic [2:0] state_dbg;

  alu_uart_host #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .timeout(timeout),
    .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full),
    .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_rel = -1;
  int rx_pops = 0;
  bit auto_reply = 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] tx_exp_q[$];
  logic       to_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] frame[$];
  int         wr_rel[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Remote ALU used to produce the reply byte.
  function automatic logic [7:0] alu_model(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o);
    case (o)
      8'h20:   return x + y;
      8'h22:   return x - y;
      8'h24:   return x & y;
      8'h25:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO pair model: RX pops on rd_uart, auto-reply after a full frame.
  always @(posedge clk) begin
    if (rd_uart && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      rx_pops++;
    end
    if (reset) begin
      frame.delete();
    end else if (wr_uart) begin
      frame.push_back(w_data);
      if (frame.size() == FRAME_LEN) begin
        if (auto_reply) rx_q.push_back(alu_model(frame[0], frame[1], frame[2]));
        frame.delete();
      end
    end
    rx_empty <= (rx_q.size() == 0);
    r_data   <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_uart) begin
      wr_cnt++;
      wr_rel.push_back(cyc - t0);
      if (tx_exp_q.size() == 0) fail_now("unexpected_tx_write");
      else chk("w_data", 32'(w_data), 32'(tx_exp_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_rel = cyc - t0;
      chk("busy_at_done", 32'(busy), 32'd1);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        chk("result", 32'(result), 32'(exp_q.pop_front()));
        chk("timeout", 32'(timeout), 32'(to_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vop,
                          input logic [7:0] res, input logic to);
    a = va; b = vb; op = vop; start = 1'b1;
    tx_exp_q.push_back(va);
    tx_exp_q.push_back(vb);
    tx_exp_q.push_back(vop);
    exp_q.push_back(res);
    to_q.push_back(to);
    wr_rel.delete();
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > base) return;
      tick();
    end
    if (done_cnt == base) fail_now("done_wait_expired");
  endtask

  task automatic rx_push(input logic [7:0] v);
    rx_q.push_back(v);
    rx_empty = 1'b0;
    r_data = rx_q[0];
  endtask

  initial begin
    logic [7:0] ops_list[4];
    logic [7:0] ra, rb, rop;
    int w0, d0;

    ops_list = '{8'h20, 8'h22, 8'h24, 8'h25};
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1] = '{8'h01, 8'h03, 8'h22, 8'hFE};
    vecs[2] = '{8'h80, 8'hFF, 8'h20, 8'h7F};
    vecs[3] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
    vecs[4] = '{8'h0F, 8'h30, 8'h25, 8'h3F};
    vecs[5] = '{8'hAA, 8'h55, 8'h99, 8'hFF};
    vecs[6] = '{8'h7F, 8'h01, 8'h20, 8'h80};

    // reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_wr_uart", 32'(wr_uart), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_rd_uart", 32'(rd_uart), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    tick();

    // basic transaction with exact timing
    do_start(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
    chk("basic_busy_c1", 32'(busy), 32'd1);
    tick(); tick(); tick();
    chk("basic_state_c4", 32'(state_dbg), 32'(WAIT_RX));
    chk("basic_rd_uart_c4", 32'(rd_uart), 32'd1);
    wait_done(20);
    chk("basic_done_cycle", 32'(done_rel), 32'd5);
    chk("basic_wr_count", 32'(wr_rel.size()), 32'd3);
    if (wr_rel.size() == 3) begin
      chk("basic_wr_c1", 32'(wr_rel[0]), 32'd1);
      chk("basic_wr_c2", 32'(wr_rel[1]), 32'd2);
      chk("basic_wr_c3", 32'(wr_rel[2]), 32'd3);
    end
    chk("basic_busy_c6", 32'(busy), 32'd0);
    chk("basic_result_hold", 32'(result), 32'h08);

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 1'b0);
      wait_done(20);
      chk("vec_latency", 32'(done_rel), 32'd5);
    end

    // random operands
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rop = ops_list[$urandom_range(0, 3)];
      do_start(ra, rb, rop, alu_model(ra, rb, rop), 1'b0);
      wait_done(20);
    end

    // TX back-pressure in cycles 2-4
    do_start(8'h11, 8'h22, 8'h20, 8'h33, 1'b0);
    tick();
    tx_full = 1'b1;
    tick(); tick();
    chk("bp_wr_stalled", 32'(wr_uart), 32'd0);
    tick();
    tx_full = 1'b0;
    wait_done(30);
    chk("bp_done_cycle", 32'(done_rel), 32'd8);
    chk("bp_wr_count", 32'(wr_rel.size()), 32'd3);
    if (wr_rel.size() == 3) begin
      chk("bp_wr_a", 32'(wr_rel[0]), 32'd1);
      chk("bp_wr_b", 32'(wr_rel[1]), 32'd5);
      chk("bp_wr_op", 32'(wr_rel[2]), 32'd6);
    end

    // stale RX byte drained in IDLE
    rx_push(8'h7F);
    #1;
    chk("stale_rd_uart", 32'(rd_uart), 32'd1);
    tick();
    chk("stale_drained", 32'(rx_q.size()), 32'd0);
    tick();
    do_start(8'h01, 8'h03, 8'h22, 8'hFE, 1'b0);
    wait_done(20);
    chk("stale_result", 32'(result), 32'hFE);

    // start while busy is ignored
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start(8'h21, 8'h04, 8'h25, 8'h25, 1'b0);
    tick();
    start = 1'b1; a = 8'hEE; b = 8'hEE; op = 8'hEE;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("busy_start_writes", 32'(wr_cnt - w0), 32'd3);
    chk("busy_start_dones", 32'(done_cnt - d0), 32'd1);

    // reset after A is written
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start(8'h44, 8'h55, 8'h20, 8'h99, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    tx_exp_q.delete();
    exp_q.delete();
    to_q.delete();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_w_data", 32'(w_data), 32'd0);
    chk("mid_rst_wr_uart", 32'(wr_uart), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd1);
    chk("mid_rst_dones", 32'(done_cnt - d0), 32'd0);
    do_start(8'h09, 8'h06, 8'h22, 8'h03, 1'b0);
    wait_done(20);
    chk("post_rst_latency", 32'(done_rel), 32'd5);

`ifdef ALU_HOST_TIMEOUT_EN
    // no reply: expiry 10 cycles after entering WAIT_RX
    auto_reply = 1'b0;
    do_start(8'h01, 8'h02, 8'h20, 8'h00, 1'b1);
    wait_done(40);
    chk("tmo_done_cycle", 32'(done_rel), 32'd14);
    tick();
    chk("tmo_low_after_done", 32'(timeout), 32'd0);

    // reply on the expiry cycle wins
    do_start(8'h01, 8'h02, 8'h20, 8'h5A, 1'b0);
    repeat (12) tick();
    rx_push(8'h5A);
    wait_done(40);
    chk("tmo_race_done_cycle", 32'(done_rel), 32'd14);
    auto_reply = 1'b1;
`endif

    repeat (3) tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("tx_exp_q_empty", 32'(tx_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
